aqalu_seq: RTL and testbench
============================

Name: aqalu_seq

Overview:
- Parametrised, handshaked successor to the 2-bit AQALU.
- Registered ALU with configurable operand width and a stateful accumulator.
- Opcode 4'b1111 is a multi-cycle timed operation driven by an internal seconds prescaler.
- Sits between the test-vector driver and the scoreboard, which checks results against out_valid instead of wall-clock delays.

Parameters:
- WIDTH, 2, operand width of a and b.
- OUT_W, 8, result width; must be >= 2*WIDTH.
- TICKS_PER_SEC, 1000, clock cycles per "second" tick.
- SEC_W, 8, width of the seconds counters.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- opcode  in  4  operation select.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- result  out  OUT_W  operation result.
- busy  out  1  timed operation in progress.
- sec_count  out  SEC_W  free-running elapsed seconds.

Behaviour:
- Reset (reset==0 at posedge):
  - Outputs: out_valid=0, result=0, busy=0, sec_count=0, in_ready=0 during the reset cycle.
  - Internal: accumulator=0, prescaler=0, state=IDLE.
  - An in-flight timed op is aborted and its result is never emitted.
- Handshake:
  - in_ready = (state!=TIMER) && (!out_valid || out_ready).
  - Accept when in_valid && in_ready; operands and opcode are sampled on that edge.
  - The result is consumed when out_valid && out_ready.
  - Accept and consume in the same cycle are legal, giving back-to-back throughput of 1 op per cycle.
  - result and out_valid must not change while out_valid && !out_ready.
- Single-cycle ops: out_valid rises on the edge after accept (latency 1). Operands are zero-extended to OUT_W and results wrap mod 2^OUT_W.
  - 0000 ADD a+b
  - 0001 SUB a-b (two's-complement wrap)
  - 0010 MUL a*b
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 NOT a (WIDTH bits, zero-extended)
  - 0111 SHL a<<b (truncated)
  - 1000 SHR a>>b
  - 1001 CMP: result[0]=a==b, result[1]=a>b, result[2]=a<b, other bits 0
  - 1010 MAX
  - 1011 MIN
  - 1100 MAC: acc<=acc+a*b, result=new acc
  - 1101 CLR: acc<=0, result=0
  - 1110 PASS a
- Timed op 1111:
  - a = number of seconds to wait (0..2^WIDTH-1); b is ignored.
  - a==0: behaves as a single-cycle op, result=0.
  - a>0:
    - Enter TIMER with busy=1; tick counter loads TICKS_PER_SEC-1 and sec_left loads a.
    - Each cycle the tick counter decrements. On wrap from 0 it reloads, sec_left decrements and elapsed increments.
    - When sec_left reaches 0: state goes to DONE and out_valid=1 with result=elapsed (zero-extended, equals a).
  - Latency from accept edge to out_valid: exactly a*TICKS_PER_SEC cycles.
  - busy drops in the same cycle out_valid rises.
- States: IDLE (no pending result), TIMER, DONE (result pending).
  - IDLE to DONE on a single-cycle accept; IDLE to TIMER on a timed accept.
  - TIMER to DONE on expiry.
  - DONE to IDLE on consume without a new accept; DONE stays DONE on consume plus a single-cycle accept; DONE to TIMER on consume plus a timed accept.
- Free-running seconds counter:
  - Prescaler counts 0..TICKS_PER_SEC-1 continuously from reset.
  - sec_count increments on the prescaler's terminal cycle and wraps mod 2^SEC_W.
  - Independent of the handshake.
- Accumulator: OUT_W bits, wraps mod 2^OUT_W, persists across ops until CLR or reset.

Decomposition:
- Package aqalu_pkg:
  - opcode constants OP_ADD..OP_TIMED
  - state enum {IDLE, TIMER, DONE}
  - CMP flag bit indices
- Sub-module aqalu_prescaler (parameters TICKS_PER_SEC, SEC_W; outputs tick pulse and sec_count). The free-running counter uses one instance; the timed op keeps its own reloadable counter.

Test Plan (WIDTH=2, OUT_W=8, TICKS_PER_SEC=10):
- Reset, then ADD a=3,b=2 with out_ready=1 -> out_valid 1 cycle after accept, result=8'd5.
- SUB a=1,b=2 -> 8'hFF. MUL 3*3 -> 8'd9. SHL a=3,b=3 -> 8'd24. CMP a=2,b=1 -> 8'b010.
- MAC a=3,b=3 four times -> results 9,18,27,36; then CLR -> 0; then MAC 1*1 -> 1.
- Timed a=3:
  - busy=1 and in_ready=0 for 30 cycles; out_valid at accept+30; result=3.
  - A second request presented during TIMER is stalled, then accepted on the consume cycle.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 1+1 -> result=2 stable, in_ready=0; release -> consumed, next op accepted the same cycle.
- Reset asserted mid-timed (a=3) at cycle 15 -> out_valid never rises, busy=0, sec_count=0, acc=0; sec_count reads 2 at cycle 20 after release.

Source files
------------

// File: rtl/aqalu_pkg.sv
// Shared definitions for the sequential AQALU: opcode map, FSM states and
// CMP result flag positions.
package aqalu_pkg;

    // Opcode map. Every 4-bit code is assigned; 4'b1111 is the timed op.
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b0110;
    localparam logic [3:0] OP_SHL   = 4'b0111;
    localparam logic [3:0] OP_SHR   = 4'b1000;
    localparam logic [3:0] OP_CMP   = 4'b1001;
    localparam logic [3:0] OP_MAX   = 4'b1010;
    localparam logic [3:0] OP_MIN   = 4'b1011;
    localparam logic [3:0] OP_MAC   = 4'b1100;
    localparam logic [3:0] OP_CLR   = 4'b1101;
    localparam logic [3:0] OP_PASS  = 4'b1110;
    localparam logic [3:0] OP_TIMED = 4'b1111;

    // IDLE: nothing pending. TIMER: timed op counting down. DONE: result held.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TIMER = 2'd1,
        DONE  = 2'd2
    } aluState_t;

    // Bit positions of the CMP flags inside result.
    localparam int CMP_EQ = 0;
    localparam int CMP_GT = 1;
    localparam int CMP_LT = 2;

endpackage

// File: rtl/aqalu_prescaler.sv
// Free-running seconds prescaler: divides the clock by TICKS_PER_SEC and
// counts elapsed "seconds", wrapping at 2^SEC_W.
module aqalu_prescaler #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int SEC_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             tick,
    output logic [SEC_W-1:0] secCount
);

    // A one-cycle second still needs a one-bit counter.
    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] preCnt;

    // The terminal count of the prescaler marks the end of a second.
    assign tick = (preCnt == LAST);

    // Count 0..TICKS_PER_SEC-1 continuously and bump the seconds on each wrap.
    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignments only, so every
        // flop samples the pre-edge values of its neighbours.
        if (!reset) begin
            preCnt   <= '0;
            secCount <= '0;
        end else if (tick) begin
            preCnt   <= '0;
            secCount <= secCount + SEC_W'(1);
        end else begin
            preCnt   <= preCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aqalu_seq.sv
// Handshaked, registered ALU with an accumulator and a multi-cycle timed op.
// One result is held at a time; a new request is taken in the same cycle the
// pending result is consumed, which gives one op per cycle back to back.
module aqalu_seq
    import aqalu_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int OUT_W         = 8,
    parameter int TICKS_PER_SEC = 1000,
    parameter int SEC_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             busy,
    output logic [SEC_W-1:0] sec_count
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICKS_PER_SEC - 1);

    aluState_t        state;
    logic [OUT_W-1:0] acc;
    logic [TICK_W-1:0] tickCnt;
    logic [WIDTH-1:0] secLeft;
    logic [WIDTH-1:0] elapsed;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] aInv;
    logic [OUT_W-1:0] aExt;
    logic [OUT_W-1:0] bExt;
    logic [OUT_W-1:0] aluResult;
    logic [OUT_W-1:0] accNext;
    logic             startTimer;
    logic             secTick;

    // Free-running elapsed-seconds counter, independent of the handshake.
    aqalu_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .SEC_W        (SEC_W)
    ) uPrescaler (
        .clock   (clock),
        .reset   (reset),
        .tick    (secTick),
        .secCount(sec_count)
    );

    // A request is taken whenever no timed op is running and the output slot
    // is free or being freed this cycle; never while reset is held.
    assign consume  = out_valid && out_ready;
    assign in_ready = reset && (state != TIMER) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Operands are unsigned and zero-extended before any arithmetic, so every
    // result wraps mod 2^OUT_W. NOT is taken at WIDTH bits and then extended.
    assign aInv = ~a;
    assign aExt = OUT_W'(a);
    assign bExt = OUT_W'(b);

    // Combinational datapath: result and next accumulator for the current request.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        aluResult  = '0;
        accNext    = acc;
        startTimer = 1'b0;
        case (opcode)
            OP_ADD:  aluResult = aExt + bExt;
            OP_SUB:  aluResult = aExt - bExt;
            OP_MUL:  aluResult = aExt * bExt;
            OP_AND:  aluResult = aExt & bExt;
            OP_OR:   aluResult = aExt | bExt;
            OP_XOR:  aluResult = aExt ^ bExt;
            OP_NOT:  aluResult = OUT_W'(aInv);
            OP_SHL:  aluResult = aExt << b;
            OP_SHR:  aluResult = aExt >> b;
            OP_CMP: begin
                aluResult[CMP_EQ] = (a == b);
                aluResult[CMP_GT] = (a > b);
                aluResult[CMP_LT] = (a < b);
            end
            OP_MAX:  aluResult = (a > b) ? aExt : bExt;
            OP_MIN:  aluResult = (a < b) ? aExt : bExt;
            OP_MAC: begin
                accNext   = acc + aExt * bExt;
                aluResult = accNext;
            end
            OP_CLR: begin
                accNext   = '0;
                aluResult = '0;
            end
            OP_PASS: aluResult = aExt;
            OP_TIMED: begin
                // A zero-second wait completes like any single-cycle op with 0.
                startTimer = (a != '0);
                aluResult  = '0;
            end
            default: aluResult = '0;
        endcase
    end

    // Control FSM with registered outputs: accept, hold until consumed, and
    // run the reloadable per-op second counter while in TIMER.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            tickCnt   <= '0;
            secLeft   <= '0;
            elapsed   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        acc <= accNext;
                        if (startTimer) begin
                            state     <= TIMER;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            tickCnt   <= TICK_RELOAD;
                            secLeft   <= a;
                            elapsed   <= '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= aluResult;
                        end
                    end else if (consume) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                TIMER: begin
                    if (tickCnt == '0) begin
                        tickCnt <= TICK_RELOAD;
                        secLeft <= secLeft - WIDTH'(1);
                        elapsed <= elapsed + WIDTH'(1);
                        // Last second ends: busy hands over to out_valid in one edge.
                        if (secLeft == WIDTH'(1)) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            result    <= OUT_W'(elapsed + WIDTH'(1));
                        end
                    end else begin
                        tickCnt <= tickCnt - TICK_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aqalu_seq.sv
// Self-checking bench for aqalu_seq (WIDTH=2, OUT_W=8, TICKS_PER_SEC=10).
// Stimulus pushes expected results into a queue; a monitor pops and compares
// each time a result is consumed.
module tb_aqalu_seq;
    import aqalu_pkg::*;

    localparam int WIDTH = 2;
    localparam int OUT_W = 8;
    localparam int TPS   = 10;
    localparam int SEC_W = 8;

    logic             clk = 1'b0;
    logic             resetN;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             outValid;
    logic             outReady;
    logic [OUT_W-1:0] result;
    logic             busy;
    logic [SEC_W-1:0] secCount;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int edges = 0;
    bit rstSeen = 1'b0;
    int lastAccept = 0;
    int accModel = 0;
    logic [OUT_W-1:0] sbQ[$];

    always #5 clk = ~clk;

    aqalu_seq #(
        .WIDTH(WIDTH), .OUT_W(OUT_W), .TICKS_PER_SEC(TPS), .SEC_W(SEC_W)
    ) dut (
        .clock(clk), .reset(resetN), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .opcode(opcode), .out_valid(outValid),
        .out_ready(outReady), .result(result), .busy(busy),
        .sec_count(secCount)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: results from plain integer arithmetic mod 256.
    function automatic logic [7:0] model(input logic [3:0] op, input int x, input int y);
        int r;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_MUL:  r = x * y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOT:  r = 3 - x;
            OP_SHL:  r = x * (1 << y);
            OP_SHR:  r = x / (1 << y);
            OP_CMP:  r = ((x == y) ? 1 : 0) + ((x > y) ? 2 : 0) + ((x < y) ? 4 : 0);
            OP_MAX:  r = (x > y) ? x : y;
            OP_MIN:  r = (x < y) ? x : y;
            OP_MAC: begin
                accModel = (accModel + x * y) % 256;
                r = accModel;
            end
            OP_CLR: begin
                accModel = 0;
                r = 0;
            end
            OP_PASS: r = x;
            default: r = x;  // timed: elapsed seconds equal a (0 when a==0)
        endcase
        return 8'(r);
    endfunction

    // Present one request and hold it until accepted (bounded wait).
    task automatic send(input logic [3:0] op, input int av, input int bv);
        int waitCnt;
        waitCnt = 0;
        opcode  = op;
        a       = WIDTH'(av);
        b       = WIDTH'(bv);
        inValid = 1'b1;
        forever begin
            @(negedge clk);
            if (inReady === 1'b1) break;
            waitCnt++;
            if (waitCnt > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: op %0d not accepted after %0d cycles", op, waitCnt);
                inValid = 1'b0;
                return;
            end
        end
        sbQ.push_back(model(op, av, bv));
        lastAccept = cyc + 1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetN) begin
            edges   <= 0;
            rstSeen <= 1'b1;
        end else begin
            edges <= edges + 1;
        end
    end

    // Monitor: compare on every consume, check stall stability and seconds.
    logic       prevStall = 1'b0;
    logic [7:0] prevRes;
    logic [7:0] expRes;
    always @(negedge clk) begin
        if (resetN === 1'b1 && rstSeen) begin
            if (prevStall) begin
                check("stall_valid", outValid, 1);
                check("stall_result", result, prevRes);
            end
            if (outValid === 1'b1 && outReady) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected no output", result);
                end else begin
                    expRes = sbQ.pop_front();
                    check("result", result, expRes);
                end
            end
            prevStall = outValid && !outReady;
            prevRes   = result;
            check("sec_count", secCount, (edges / TPS) % 256);
        end else begin
            prevStall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] rop;
        int ra, rb, tAcc, rel, k, prevAcc;
        bit randDone, seenValid;

        resetN = 1'b0; inValid = 1'b0; a = '0; b = '0; opcode = '0; outReady = 1'b1;
        randDone = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", outValid, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_sec_count", secCount, 0);
        check("rst_in_ready", inReady, 0);
        resetN = 1'b1;

        // Directed single-cycle ops, back to back.
        send(OP_ADD, 3, 2);
        check("add_latency", outValid, 1);
        prevAcc = lastAccept;
        send(OP_SUB, 1, 2);
        check("back_to_back", lastAccept, prevAcc + 1);
        send(OP_MUL, 3, 3);
        send(OP_SHL, 3, 3);
        send(OP_CMP, 2, 1);
        repeat (4) send(OP_MAC, 3, 3);
        send(OP_CLR, 0, 0);
        send(OP_MAC, 1, 1);

        // Timed a=3 with a second request stalled behind it.
        send(OP_TIMED, 3, 0);
        tAcc = lastAccept;
        fork
            begin
                int n;
                bit stallOk;
                n = 0;
                stallOk = 1'b1;
                while (outValid !== 1'b1 && n < 100) begin
                    if (busy !== 1'b1 || inReady !== 1'b0) stallOk = 1'b0;
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("timed_latency", n, 30);
                check("timed_busy_stall", stallOk, 1);
                check("timed_busy_drop", busy, 0);
            end
            send(OP_ADD, 1, 2);
        join
        check("stalled_accept_cycle", lastAccept, tAcc + 31);

        // Backpressure: hold the ADD 1+1 result for 5 cycles.
        @(posedge clk);
        #1;
        outReady = 1'b0;
        send(OP_ADD, 1, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", outValid, 1);
            check("bp_result", result, 2);
            check("bp_in_ready", inReady, 0);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        rel = cyc;
        send(OP_XOR, 2, 3);
        check("bp_release_accept", lastAccept, rel + 1);

        // Randomized ops under random backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    rop = 4'($urandom_range(0, 15));
                    ra  = $urandom_range(0, 3);
                    rb  = $urandom_range(0, 3);
                    if (rop == OP_TIMED) ra = $urandom_range(0, 1);
                    send(rop, ra, rb);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk);
                    #1;
                    outReady = ($urandom_range(0, 3) != 0);
                end
            end
        join
        outReady = 1'b1;
        k = 0;
        while (sbQ.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_random", sbQ.size(), 0);

        // Reset in the middle of a timed op.
        send(OP_TIMED, 3, 0);
        repeat (15) @(posedge clk);
        #1;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", outValid, 0);
        check("abort_sec_count", secCount, 0);
        check("abort_in_ready", inReady, 0);
        sbQ.delete();
        accModel = 0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        seenValid = 1'b0;
        repeat (19) begin
            @(posedge clk);
            #1;
            if (outValid !== 1'b0) seenValid = 1'b1;
        end
        check("sec_count_19", secCount, 1);
        @(posedge clk);
        #1;
        if (outValid !== 1'b0) seenValid = 1'b1;
        check("sec_count_20", secCount, 2);
        check("abort_no_result", seenValid, 0);
        check("abort_busy_after", busy, 0);

        // Accumulator cleared by reset: MAC 1*1 gives 1.
        send(OP_MAC, 1, 1);
        k = 0;
        while (sbQ.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_final", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
